// File: rtl/reduce_gate_unit.sv
// reduce_gate_unit
// Registered AND / OR / XOR reduction of a WIDTH-bit operand, qualified by
// in_valid. It serves as a small status and parity generator in the datapath.
// Optional feature macro: REDUCE_POPCOUNT_EN adds cnt_out, the registered
// population count of the captured operand.
module reduce_gate_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    output logic             y_out,
    output logic             o_out,
`ifdef REDUCE_POPCOUNT_EN
    output logic             xo_out,
    output logic [$clog2(WIDTH+1)-1:0] cnt_out
`else
    output logic             xo_out
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Reduction gates, kept as functions so each operator lives in one place.
    function automatic logic reduce_and(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

    function automatic logic reduce_or(input logic [WIDTH-1:0] v);
        return |v;
    endfunction

    function automatic logic reduce_xor(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic and_c;
    logic or_c;
    logic xor_c;

    logic vld_d, vld_q;
    logic y_d,   y_q;
    logic o_d,   o_q;
    logic xo_d,  xo_q;

    assign and_c = reduce_and(a);
    assign or_c  = reduce_or(a);
    assign xor_c = reduce_xor(a);

    // Next state: load the reductions on a valid operand, otherwise hold.
    // Gating on in_valid keeps an X/Z operand from reaching the registers.
    always_comb begin
        vld_d = in_valid;
        y_d   = y_q;
        o_d   = o_q;
        xo_d  = xo_q;
        if (in_valid) begin
            y_d  = and_c;
            o_d  = or_c;
            xo_d = xor_c;
        end
    end

    // Result registers; reset clears results and drops any operand in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            y_q   <= 1'b0;
            o_q   <= 1'b0;
            xo_q  <= 1'b0;
        end else begin
            vld_q <= vld_d;
            y_q   <= y_d;
            o_q   <= o_d;
            xo_q  <= xo_d;
        end
    end

    assign out_valid = vld_q;
    assign y_out     = y_q;
    assign o_out     = o_q;
    assign xo_out    = xo_q;

`ifdef REDUCE_POPCOUNT_EN
    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    logic [CNT_W-1:0] cnt_c;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign cnt_c = popcount(a);

    // Count follows the same load/hold rule as the other results.
    always_comb begin
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = cnt_c;
        end
    end

    // Count register, cleared with the rest of the results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_reduce_gate_unit.sv
// Testbench for reduce_gate_unit: WIDTH=4, WIDTH=1 and WIDTH=8 instances,
// queue-based scoreboards with one monitor per instance.
module tb_reduce_gate_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       iv4, ov4, y4, o4, x4;
    logic [3:0] a4;
    logic       iv1, ov1, y1, o1, x1;
    logic [0:0] a1;
    logic       iv8, ov8, y8, o8, x8;
    logic [7:0] a8;
`ifdef REDUCE_POPCOUNT_EN
    logic [2:0] c4;
    logic [0:0] c1;
    logic [3:0] c8;
`endif

    reduce_gate_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .out_valid(ov4),
        .y_out(y4), .o_out(o4),
`ifdef REDUCE_POPCOUNT_EN
        .xo_out(x4), .cnt_out(c4)
`else
        .xo_out(x4)
`endif
    );

    reduce_gate_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .out_valid(ov1),
        .y_out(y1), .o_out(o1),
`ifdef REDUCE_POPCOUNT_EN
        .xo_out(x1), .cnt_out(c1)
`else
        .xo_out(x1)
`endif
    );

    reduce_gate_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .out_valid(ov8),
        .y_out(y8), .o_out(o8),
`ifdef REDUCE_POPCOUNT_EN
        .xo_out(x8), .cnt_out(c8)
`else
        .xo_out(x8)
`endif
    );

    typedef struct {
        logic y;
        logic o;
        logic xo;
        int   cnt;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t q8[$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic exp_t mk(input logic y, input logic o, input logic xo, input int cnt);
        exp_t e;
        e.y   = y;
        e.o   = o;
        e.xo  = xo;
        e.cnt = cnt;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the WIDTH=4 instance: invariants every cycle, scoreboard on out_valid.
    always @(negedge clk) begin : mon4
        exp_t e;
        check("w4_invariant", int'((y4 && !o4) || (!o4 && (y4 || x4))), 0);
        if (ov4) begin
            if (q4.size() == 0) begin
                check("w4_unexpected_valid", 1, 0);
            end else begin
                e = q4.pop_front();
                check("w4_y", int'(y4), int'(e.y));
                check("w4_o", int'(o4), int'(e.o));
                check("w4_xo", int'(x4), int'(e.xo));
`ifdef REDUCE_POPCOUNT_EN
                check("w4_cnt", int'(c4), e.cnt);
`endif
            end
        end
    end

    // Monitor for the WIDTH=1 instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (ov1) begin
            if (q1.size() == 0) begin
                check("w1_unexpected_valid", 1, 0);
            end else begin
                e = q1.pop_front();
                check("w1_y", int'(y1), int'(e.y));
                check("w1_o", int'(o1), int'(e.o));
                check("w1_xo", int'(x1), int'(e.xo));
`ifdef REDUCE_POPCOUNT_EN
                check("w1_cnt", int'(c1), e.cnt);
`endif
            end
        end
    end

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (ov8) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_valid", 1, 0);
            end else begin
                e = q8.pop_front();
                check("w8_y", int'(y8), int'(e.y));
                check("w8_o", int'(o8), int'(e.o));
                check("w8_xo", int'(x8), int'(e.xo));
`ifdef REDUCE_POPCOUNT_EN
                check("w8_cnt", int'(c8), e.cnt);
`endif
            end
        end
    end

    task automatic send4(input logic [3:0] v, input exp_t e);
        @(posedge clk);
        #1;
        iv4 = 1'b1;
        a4  = v;
        q4.push_back(e);
    endtask

    task automatic idle4();
        @(posedge clk);
        #1;
        iv4 = 1'b0;
    endtask

    task automatic check_zero4(input string name);
        check({name, "_valid"}, int'(ov4), 0);
        check({name, "_y"}, int'(y4), 0);
        check({name, "_o"}, int'(o4), 0);
        check({name, "_xo"}, int'(x4), 0);
`ifdef REDUCE_POPCOUNT_EN
        check({name, "_cnt"}, int'(c4), 0);
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] dv[6];
    logic [2:0] de[6];
    int         dc[6];

    initial begin : stim
        dv = '{4'b0000, 4'b0111, 4'b0000, 4'b1111, 4'b0010, 4'b0000};
        de = '{3'b000, 3'b011, 3'b000, 3'b110, 3'b011, 3'b000};
        dc = '{0, 3, 0, 4, 1, 0};

        rst = 1'b1;
        iv4 = 1'b0; a4 = '0;
        iv1 = 1'b0; a1 = '0;
        iv8 = 1'b0; a8 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_zero4("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;

        // Load non-zero results, then assert reset asynchronously mid-cycle
        send4(4'b1111, mk(1'b1, 1'b1, 1'b0, 4));
        idle4();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero4("async_reset");
        repeat (3) begin
            @(negedge clk);
            check_zero4("reset_hold");
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed back-to-back vectors
        for (int i = 0; i < 6; i++) begin
            send4(dv[i], mk(de[i][2], de[i][1], de[i][0], dc[i]));
        end
        idle4();

        // Hold: results persist and out_valid drops while in_valid is low
        send4(4'b1111, mk(1'b1, 1'b1, 1'b0, 4));
        @(posedge clk);
        #1;
        iv4 = 1'b0;
        a4  = 4'b0000;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", int'(ov4), 0);
            check("hold_y", int'(y4), 1);
            check("hold_o", int'(o4), 1);
            check("hold_xo", int'(x4), 0);
`ifdef REDUCE_POPCOUNT_EN
            check("hold_cnt", int'(c4), 4);
`endif
        end

        // Exhaustive over WIDTH=4
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            send4(v, mk(v == 4'hF, v != 4'h0, ($countones(v) % 2) == 1, $countones(v)));
        end
        idle4();

        // Reset mid-stream: operand 0111 is presented but reset hits before capture
        @(posedge clk);
        #1;
        iv4 = 1'b1;
        a4  = 4'b0111;
        #3 rst = 1'b1;
        #1 check_zero4("midstream_reset");
        @(posedge clk);
        #1 iv4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_zero4("midstream_after");
        end
        send4(4'b0010, mk(1'b0, 1'b1, 1'b1, 1));
        idle4();

        // Parameter sweep: WIDTH=1
        @(posedge clk);
        #1; iv1 = 1'b1; a1 = 1'b1; q1.push_back(mk(1'b1, 1'b1, 1'b1, 1));
        @(posedge clk);
        #1; iv1 = 1'b1; a1 = 1'b0; q1.push_back(mk(1'b0, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1; iv1 = 1'b0;

        // Parameter sweep: WIDTH=8
        @(posedge clk);
        #1; iv8 = 1'b1; a8 = 8'h81; q8.push_back(mk(1'b0, 1'b1, 1'b0, 2));
        @(posedge clk);
        #1; iv8 = 1'b0;

        // Every issued operand must have produced exactly one result
        repeat (3) @(negedge clk);
        check("w4_queue_drained", q4.size(), 0);
        check("w1_queue_drained", q1.size(), 0);
        check("w8_queue_drained", q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
